bin_quiz_engine: RTL and testbench

- Parametrised successor to the decimal-to-binary quiz datapath/control pair.
- Player enters NUM_DIGITS decimal digits via one-hot switches, then converts the number to binary on answer switches before a countdown expires.
- Adds edge-detected buttons, an iterative multi-cycle converter, configurable time limit and wrong-guess penalty, a restartable game loop, and a persistent win counter.
- Sits between board I/O (already-inverted KEYs, SW) and the hex decoders and LEDs.

---
 rtl/bin_quiz_engine.sv | 167 ++++++++++++++++
 tb/tb_bin_quiz_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_quiz_engine.sv
// bin_quiz_engine: decimal-to-binary quiz game.
// Player keys in NUM_DIGITS decimal digits, an iterative converter builds the
// binary answer, then the player must match it on sw_ans_i before the
// countdown runs out. Wrong guesses cost PENALTY seconds.
module bin_quiz_engine #(
    parameter int NUM_DIGITS  = 4,
    parameter int ANS_W       = 14,
    parameter int CLK_PER_SEC = 50000000,
    parameter int TIME_LIMIT  = 30,
    parameter int PENALTY     = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    next_i,
    input  logic                    go_i,
    input  logic                    check_i,
    input  logic [9:0]              sw_onehot_i,
    input  logic [ANS_W-1:0]        sw_ans_i,
    input  logic                    hint_en_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [3:0]              time_tens_o,
    output logic [3:0]              time_ones_o,
    output logic [ANS_W-1:0]        hint_mask_o,
    output logic                    won_o,
    output logic                    lost_o,
    output logic                    busy_o,
    output logic [3:0]              wins_o
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PS_W-1:0]  PS_MAX = PS_W'(CLK_PER_SEC - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ANS_W-1:0] TEN = ANS_W'(10);

    typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_PLAY, S_WIN, S_LOSE} state_t;

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [ANS_W-1:0]        acc_q, acc_d;
    logic [ANS_W-1:0]        answer_q, answer_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              timer_q, timer_d;
    logic [PS_W-1:0]         presc_q, presc_d;
    logic [3:0]              wins_q, wins_d;
    logic [2:0]              btn_q;

    logic       next_ev, go_ev, check_ev;
    logic [3:0] oh_cnt, oh_dig;
    logic [3:0] cur_dig;
    logic       sec_tick;
    logic [7:0] dec;
    logic       show_time;

    // Press events: rising edge of each button against its registered copy.
    assign next_ev  = next_i  & ~btn_q[0];
    assign go_ev    = go_i    & ~btn_q[1];
    assign check_ev = check_i & ~btn_q[2];

    assign cur_dig  = digits_q[4*int'(idx_q) +: 4];
    assign sec_tick = (presc_q == PS_MAX);

    // Count set switches and encode the (last) set one; only a count of 1 is accepted.
    always_comb begin
        oh_cnt = '0;
        oh_dig = '0;
        for (int k = 0; k < 10; k++) begin
            if (sw_onehot_i[k]) begin
                oh_cnt = oh_cnt + 4'd1;
                oh_dig = 4'(k);
            end
        end
    end

    // Game FSM next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        acc_d    = acc_q;
        answer_d = answer_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        presc_d  = presc_q;
        wins_d   = wins_q;
        dec      = '0;
        case (state_q)
            S_IDLE: begin
                if (go_ev) begin
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                    state_d = S_CONVERT;
                end else if (next_ev && oh_cnt == 4'd1) begin
                    digits_d = (digits_q << 4) | (4*NUM_DIGITS)'(oh_dig);
                end
            end
            S_CONVERT: begin
                // Horner step, most significant digit first, wrapping at ANS_W bits.
                acc_d = acc_q * TEN + ANS_W'(cur_dig);
                if (idx_q == '0) begin
                    answer_d = acc_d;
                    timer_d  = 7'(TIME_LIMIT);
                    presc_d  = '0;
                    state_d  = S_PLAY;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_PLAY: begin
                if (timer_q == '0) begin
                    state_d = S_LOSE;
                end else begin
                    presc_d = sec_tick ? '0 : presc_q + PS_W'(1);
                    if (check_ev && sw_ans_i == answer_q) begin
                        // A correct answer beats a simultaneous final tick.
                        state_d = S_WIN;
                        if (wins_q != 4'hF) wins_d = wins_q + 4'd1;
                    end else begin
                        dec = 8'(sec_tick) + (check_ev ? 8'(PENALTY) : 8'd0);
                        timer_d = (dec >= {1'b0, timer_q}) ? 7'd0 : 7'({1'b0, timer_q} - dec);
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (go_ev) begin
                    digits_d = '0;
                    answer_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and button edge registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            digits_q <= '0;
            acc_q    <= '0;
            answer_q <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            presc_q  <= '0;
            wins_q   <= '0;
            btn_q    <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            acc_q    <= acc_d;
            answer_q <= answer_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            presc_q  <= presc_d;
            wins_q   <= wins_d;
            btn_q    <= {check_i, go_i, next_i};
        end
    end

    assign show_time   = (state_q == S_PLAY) || (state_q == S_WIN) || (state_q == S_LOSE);
    assign time_tens_o = show_time ? 4'(timer_q / 7'd10) : 4'd0;
    assign time_ones_o = show_time ? 4'(timer_q % 7'd10) : 4'd0;
    assign hint_mask_o = (hint_en_i && state_q == S_PLAY) ? (answer_q ^ sw_ans_i) : '0;
    assign digits_o    = digits_q;
    assign won_o       = (state_q == S_WIN);
    assign lost_o      = (state_q == S_LOSE);
    assign busy_o      = (state_q == S_CONVERT) || (state_q == S_PLAY);
    assign wins_o      = wins_q;
endmodule

// File: tb/tb_bin_quiz_engine.sv
// Scoreboard bench for bin_quiz_engine: a game-level reference model predicts
// every cycle's outputs, a monitor compares them after each clock edge.
module tb_bin_quiz_engine;
    localparam int ND = 4, AW = 14, CPS = 4, TL = 30, PEN = 5;
    localparam int P_ENTER = 0, P_CONV = 1, P_PLAY = 2, P_WON = 3, P_LOST = 4;

    typedef logic [4*ND+8+AW+3+4-1:0] obs_t;

    logic clk = 1'b0;
    logic resetn = 1'b0, next_i = 1'b0, go_i = 1'b0, check_i = 1'b0, hint_en_i = 1'b0;
    logic [9:0]      sw_onehot_i = '0;
    logic [AW-1:0]   sw_ans_i = '0;
    logic [4*ND-1:0] digits_o;
    logic [3:0]      time_tens_o, time_ones_o, wins_o;
    logic [AW-1:0]   hint_mask_o;
    logic            won_o, lost_o, busy_o;

    int checks = 0, failures = 0;
    obs_t exp_q[$];
    obs_t mon_e, mon_a;

    bin_quiz_engine #(.NUM_DIGITS(ND), .ANS_W(AW), .CLK_PER_SEC(CPS),
                      .TIME_LIMIT(TL), .PENALTY(PEN)) dut (
        .clk(clk), .resetn(resetn), .next_i(next_i), .go_i(go_i), .check_i(check_i),
        .sw_onehot_i(sw_onehot_i), .sw_ans_i(sw_ans_i), .hint_en_i(hint_en_i),
        .digits_o(digits_o), .time_tens_o(time_tens_o), .time_ones_o(time_ones_o),
        .hint_mask_o(hint_mask_o), .won_o(won_o), .lost_o(lost_o), .busy_o(busy_o),
        .wins_o(wins_o));

    always #5 clk = ~clk;

    // Reference model: game phase, digit list, answer value, seconds left.
    int m_phase = P_ENTER, m_answer = 0, m_timer = 0, m_presc = 0, m_wins = 0, m_conv_left = 0;
    int m_dig[ND];
    bit m_pn = 0, m_pg = 0, m_pc = 0;

    task automatic model_edge();
        bit en, eg, ec, sec;
        int v;
        if (!resetn) begin
            m_phase = P_ENTER; m_answer = 0; m_timer = 0; m_presc = 0; m_wins = 0;
            m_conv_left = 0; m_pn = 0; m_pg = 0; m_pc = 0;
            for (int i = 0; i < ND; i++) m_dig[i] = 0;
            return;
        end
        en = next_i && !m_pn; eg = go_i && !m_pg; ec = check_i && !m_pc;
        m_pn = next_i; m_pg = go_i; m_pc = check_i;
        case (m_phase)
            P_ENTER: begin
                if (eg) begin
                    m_phase = P_CONV; m_conv_left = ND;
                end else if (en && $countones(sw_onehot_i) == 1) begin
                    for (int i = ND - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
                    m_dig[0] = $clog2(sw_onehot_i);
                end
            end
            P_CONV: begin
                m_conv_left--;
                if (m_conv_left == 0) begin
                    v = 0;
                    for (int i = ND - 1; i >= 0; i--) v = v * 10 + m_dig[i];
                    m_answer = v % (1 << AW);
                    m_timer = TL; m_presc = 0; m_phase = P_PLAY;
                end
            end
            P_PLAY: begin
                if (m_timer == 0) m_phase = P_LOST;
                else begin
                    sec = (m_presc == CPS - 1);
                    m_presc = sec ? 0 : m_presc + 1;
                    if (ec && int'(sw_ans_i) == m_answer) begin
                        m_phase = P_WON;
                        if (m_wins < 15) m_wins++;
                    end else begin
                        m_timer = m_timer - (sec ? 1 : 0) - (ec ? PEN : 0);
                        if (m_timer < 0) m_timer = 0;
                    end
                end
            end
            default: begin
                if (eg) begin
                    m_phase = P_ENTER; m_answer = 0;
                    for (int i = 0; i < ND; i++) m_dig[i] = 0;
                end
            end
        endcase
    endtask

    function automatic obs_t model_out();
        logic [4*ND-1:0] d;
        logic [3:0] tt, to;
        logic [AW-1:0] h;
        bit show;
        for (int i = 0; i < ND; i++) d[4*i +: 4] = 4'(m_dig[i]);
        show = (m_phase == P_PLAY) || (m_phase == P_WON) || (m_phase == P_LOST);
        tt = show ? 4'(m_timer / 10) : 4'd0;
        to = show ? 4'(m_timer % 10) : 4'd0;
        h  = (m_phase == P_PLAY && hint_en_i) ? (AW'(m_answer) ^ sw_ans_i) : '0;
        return {d, tt, to, h, (m_phase == P_WON), (m_phase == P_LOST),
                (m_phase == P_CONV || m_phase == P_PLAY), 4'(m_wins)};
    endfunction

    // One clock: predict the edge, queue the expected outputs, wait for negedge.
    task automatic tick();
        model_edge();
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press_next(input logic [9:0] oh);
        sw_onehot_i = oh; next_i = 1'b1; tick(); next_i = 1'b0; tick();
    endtask

    task automatic press_go();
        go_i = 1'b1; tick(); go_i = 1'b0; tick();
    endtask

    // Monitor: compare every output after each edge against the queued prediction.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {digits_o, time_tens_o, time_ones_o, hint_mask_o, won_o, lost_o, busy_o, wins_o};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL outputs t=%0t got {dig,tt,to,hint,won,lost,busy,wins}=%h expected %h",
                         $time, mon_a, mon_e);
            end
        end
    end

    initial begin
        // Reset with check held across the release.
        resetn = 1'b0; check_i = 1'b1;
        repeat (3) tick();
        chk("reset_digits", 32'(digits_o), 0);
        chk("reset_flags", {won_o, lost_o, busy_o}, 0);
        chk("reset_wins", 32'(wins_o), 0);
        resetn = 1'b1;
        repeat (2) tick();
        check_i = 1'b0; tick();
        chk("held_check_no_event", {won_o, lost_o, busy_o}, 0);

        // Digit entry 1,2,3,4 then rejected patterns.
        for (int d = 1; d <= 4; d++) press_next(10'd1 << d);
        press_next(10'b0000000011);
        press_next(10'b0);
        chk("entry_digits", 32'(digits_o), 32'h1234);

        // Conversion: busy for ND cycles without a time display, then PLAY at 30.
        go_i = 1'b1; tick(); go_i = 1'b0;
        chk("convert_busy_first", 32'(busy_o), 1);
        for (int c = 0; c < ND - 1; c++) tick();
        chk("convert_no_time", 32'(time_tens_o), 0);
        tick();
        chk("play_tens", 32'(time_tens_o), 3);
        chk("play_ones", 32'(time_ones_o), 0);
        hint_en_i = 1'b1; sw_ans_i = '0; #1;
        chk("hint_mask", 32'(hint_mask_o), 32'h04D2);

        // Wrong check: 30 -> 25.
        check_i = 1'b1; tick(); check_i = 1'b0;
        chk("penalty_tens", 32'(time_tens_o), 2);
        chk("penalty_ones", 32'(time_ones_o), 5);
        tick();

        // Correct check wins; timer freezes.
        sw_ans_i = 14'd1234; check_i = 1'b1; tick(); check_i = 1'b0;
        chk("win_flag", 32'(won_o), 1);
        chk("win_count", 32'(wins_o), 1);
        repeat (3 * CPS) tick();
        chk("win_frozen", {time_tens_o, time_ones_o}, 32'h25);
        press_go();
        chk("restart_digits", 32'(digits_o), 0);
        chk("restart_wins", 32'(wins_o), 1);
        chk("restart_won", 32'(won_o), 0);

        // Holding next gives a single shift.
        sw_onehot_i = 10'd1 << 7; next_i = 1'b1;
        repeat (20) tick();
        next_i = 1'b0; tick();
        chk("hold_next_digits", 32'(digits_o), 32'h0007);

        // Timeout with no checks.
        hint_en_i = 1'b0;
        go_i = 1'b1; tick(); go_i = 1'b0;
        repeat (ND + TL * CPS) tick();
        chk("timeout_zero_still_play", {lost_o, busy_o, time_tens_o, time_ones_o}, 32'h100);
        tick();
        chk("timeout_lost", 32'(lost_o), 1);

        // Six wrong checks drain the timer.
        press_go();
        go_i = 1'b1; tick(); go_i = 1'b0;
        repeat (ND) tick();
        for (int k = 0; k < 6; k++) begin
            sw_ans_i = AW'(m_answer) ^ 14'd1;
            check_i = 1'b1; tick(); check_i = 1'b0; tick();
        end
        tick();
        chk("penalty_lost", 32'(lost_o), 1);

        // Reset in the middle of a game clears everything including wins.
        press_go();
        go_i = 1'b1; tick(); go_i = 1'b0;
        repeat (ND + 3) tick();
        resetn = 1'b0; check_i = 1'b1;
        repeat (2) tick();
        chk("midreset_wins", 32'(wins_o), 0);
        chk("midreset_busy", 32'(busy_o), 0);
        resetn = 1'b1; repeat (2) tick(); check_i = 1'b0; tick();
        chk("midreset_idle", {won_o, lost_o, busy_o, time_tens_o, time_ones_o}, 0);

        // Randomised play against the model.
        for (int n = 0; n < 4000; n++) begin
            resetn    = ($urandom_range(0, 999) != 0);
            next_i    = ($urandom_range(0, 2) == 0);
            go_i      = ($urandom_range(0, 11) == 0);
            check_i   = ($urandom_range(0, 3) == 0);
            hint_en_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) sw_onehot_i = 10'd1 << $urandom_range(0, 9);
            else sw_onehot_i = 10'($urandom);
            if ($urandom_range(0, 1) != 0) sw_ans_i = AW'(m_answer);
            else sw_ans_i = AW'($urandom);
            tick();
        end
        resetn = 1'b1; next_i = 1'b0; go_i = 1'b0; check_i = 1'b0;
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
